// File: rtl/plate_window_ctrl.sv
// Frame-level SEARCH/TRACK controller for the plate horizontal-projection window.
// Validates the row/column edges once per frame and reprograms the projection column window.
module plate_window_ctrl #(
    parameter logic [9:0] IMG_HDISP   = 10'd640,
    parameter logic [9:0] MIN_H       = 10'd16,
    parameter logic [9:0] MAX_H       = 10'd160,
    parameter logic [9:0] MIN_W       = 10'd60,
    parameter logic [9:0] MAX_W       = 10'd400,
    parameter logic [9:0] MARGIN      = 10'd8,
    parameter logic [2:0] LOCK_FRAMES = 3'd2,
    parameter logic [2:0] MISS_FRAMES = 3'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       per_frame_vsync,
    input  logic [9:0] max_line_up,
    input  logic [9:0] max_line_down,
    input  logic [9:0] max_col_left,
    input  logic [9:0] max_col_right,
    output logic [9:0] horizon_start,
    output logic [9:0] horizon_end,
    output logic [9:0] plate_top,
    output logic [9:0] plate_bottom,
    output logic [9:0] plate_left,
    output logic [9:0] plate_right,
    output logic       plate_valid,
    output logic       eval_pulse,
    output logic       eval_ok
);

    typedef enum logic {SEARCH = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [9:0] HMAX = IMG_HDISP - 10'd1;

    state_t     state, state_nx;
    logic       vsync_d, pend1, pend2, vsync_fall;
    logic [2:0] hit_cnt, hit_nx, miss_cnt, miss_nx;
    logic [9:0] hs_nx, he_nx, pt_nx, pb_nx, pl_nx, pr_nx;
    logic       pv_nx, ok_nx, pulse_nx;

    logic       frame_ok;
    logic [9:0] height, width, win_lo, win_hi;
    logic [10:0] hi_sum;

    assign vsync_fall = vsync_d & ~per_frame_vsync;

    // Differences are only meaningful once the ordering check holds.
    assign height   = max_line_down - max_line_up;
    assign width    = max_col_right - max_col_left;
    assign frame_ok = (max_line_up < max_line_down) && (height >= MIN_H) && (height <= MAX_H) &&
                      (max_col_left < max_col_right) && (width >= MIN_W) && (width <= MAX_W);

    assign win_lo = (max_col_left < MARGIN) ? 10'd0 : (max_col_left - MARGIN);
    assign hi_sum = {1'b0, max_col_right} + {1'b0, MARGIN};
    assign win_hi = (hi_sum > {1'b0, HMAX}) ? HMAX : hi_sum[9:0];

    always_comb begin
        state_nx = state;
        hit_nx   = hit_cnt;
        miss_nx  = miss_cnt;
        hs_nx    = horizon_start;
        he_nx    = horizon_end;
        pt_nx    = plate_top;
        pb_nx    = plate_bottom;
        pl_nx    = plate_left;
        pr_nx    = plate_right;
        pv_nx    = plate_valid;
        ok_nx    = eval_ok;
        pulse_nx = 1'b0;
        if (!en) begin
            state_nx = SEARCH;
            hs_nx    = 10'd0;
            he_nx    = HMAX;
            pv_nx    = 1'b0;
            hit_nx   = 3'd0;
            miss_nx  = 3'd0;
        end else if (pend2) begin
            pulse_nx = 1'b1;
            ok_nx    = frame_ok;
            case (state)
                SEARCH: begin
                    if (!frame_ok) begin
                        hit_nx = 3'd0;
                    end else if ({1'b0, hit_cnt} + 4'd1 >= {1'b0, LOCK_FRAMES}) begin
                        state_nx = TRACK;
                        pv_nx    = 1'b1;
                        hit_nx   = 3'd0;
                        pt_nx    = max_line_up;
                        pb_nx    = max_line_down;
                        pl_nx    = max_col_left;
                        pr_nx    = max_col_right;
                        hs_nx    = win_lo;
                        he_nx    = win_hi;
                    end else begin
                        hit_nx = (hit_cnt == 3'd7) ? 3'd7 : hit_cnt + 3'd1;
                    end
                end
                TRACK: begin
                    if (frame_ok) begin
                        miss_nx = 3'd0;
                        pt_nx   = max_line_up;
                        pb_nx   = max_line_down;
                        pl_nx   = max_col_left;
                        pr_nx   = max_col_right;
                        hs_nx   = win_lo;
                        he_nx   = win_hi;
                    end else if ({1'b0, miss_cnt} + 4'd1 >= {1'b0, MISS_FRAMES}) begin
                        state_nx = SEARCH;
                        pv_nx    = 1'b0;
                        miss_nx  = 3'd0;
                        hs_nx    = 10'd0;
                        he_nx    = HMAX;
                    end else begin
                        miss_nx = (miss_cnt == 3'd7) ? 3'd7 : miss_cnt + 3'd1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SEARCH;
            vsync_d       <= 1'b0;
            pend1         <= 1'b0;
            pend2         <= 1'b0;
            hit_cnt       <= 3'd0;
            miss_cnt      <= 3'd0;
            horizon_start <= 10'd0;
            horizon_end   <= HMAX;
            plate_top     <= 10'd0;
            plate_bottom  <= 10'd0;
            plate_left    <= 10'd0;
            plate_right   <= 10'd0;
            plate_valid   <= 1'b0;
            eval_pulse    <= 1'b0;
            eval_ok       <= 1'b0;
        end else begin
            vsync_d       <= per_frame_vsync;
            // A fall while an evaluation is already in flight is dropped.
            pend1         <= en & vsync_fall & ~pend1 & ~pend2;
            pend2         <= en & pend1;
            state         <= state_nx;
            hit_cnt       <= hit_nx;
            miss_cnt      <= miss_nx;
            horizon_start <= hs_nx;
            horizon_end   <= he_nx;
            plate_top     <= pt_nx;
            plate_bottom  <= pb_nx;
            plate_left    <= pl_nx;
            plate_right   <= pr_nx;
            plate_valid   <= pv_nx;
            eval_pulse    <= pulse_nx;
            eval_ok       <= ok_nx;
        end
    end

endmodule

// File: tb/tb_plate_window_ctrl.sv
// Bench for plate_window_ctrl: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_plate_window_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, per_frame_vsync;
    logic [9:0] max_line_up, max_line_down, max_col_left, max_col_right;
    logic [9:0] horizon_start, horizon_end, plate_top, plate_bottom, plate_left, plate_right;
    logic       plate_valid, eval_pulse, eval_ok;

    int errors = 0;
    int checks = 0;

    plate_window_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .per_frame_vsync(per_frame_vsync),
        .max_line_up(max_line_up), .max_line_down(max_line_down),
        .max_col_left(max_col_left), .max_col_right(max_col_right),
        .horizon_start(horizon_start), .horizon_end(horizon_end),
        .plate_top(plate_top), .plate_bottom(plate_bottom),
        .plate_left(plate_left), .plate_right(plate_right),
        .plate_valid(plate_valid), .eval_pulse(eval_pulse), .eval_ok(eval_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: frame-level rules over plain integers.
    int  m_lo, m_hi, m_box[4], m_hits, m_miss, m_age;
    bit  m_locked, m_ok, m_pulse, m_prev_vs, m_have;

    task automatic model_step();
        int u, d, l, r;
        bit fall_ok, ok;
        if (rst) begin
            m_locked = 0; m_lo = 0; m_hi = 639; m_box = '{0, 0, 0, 0};
            m_hits = 0; m_miss = 0; m_age = -1; m_ok = 0; m_pulse = 0; m_prev_vs = 0;
            m_have = 1;
            return;
        end
        fall_ok = m_prev_vs && !per_frame_vsync && (m_age < 0);
        m_prev_vs = per_frame_vsync;
        m_pulse = 0;
        if (!en) begin
            m_locked = 0; m_lo = 0; m_hi = 639; m_hits = 0; m_miss = 0; m_age = -1;
            return;
        end
        if (m_age == 2) begin
            u = max_line_up; d = max_line_down; l = max_col_left; r = max_col_right;
            ok = (u < d) && (d - u >= 16) && (d - u <= 160) && (l < r) && (r - l >= 60) && (r - l <= 400);
            m_pulse = 1; m_ok = ok; m_age = -1;
            if (ok && (m_locked || m_hits + 1 >= 2)) begin
                m_locked = 1; m_hits = 0; m_miss = 0; m_box = '{u, d, l, r};
                m_lo = (l - 8 < 0) ? 0 : l - 8;
                m_hi = (r + 8 > 639) ? 639 : r + 8;
            end else if (ok) begin
                m_hits++;
            end else if (!m_locked) begin
                m_hits = 0;
            end else begin
                m_miss++;
                if (m_miss >= 3) begin
                    m_locked = 0; m_miss = 0; m_lo = 0; m_hi = 639;
                end
            end
        end else if (m_age >= 0) begin
            m_age++;
        end
        if (fall_ok) m_age = 1;
    endtask

    // Inputs change just after posedge, so at negedge they are what the next edge samples.
    initial begin
        m_have = 0;
        forever begin
            @(negedge clk);
            if (m_have) begin
                chk("horizon_start", horizon_start, m_lo);
                chk("horizon_end", horizon_end, m_hi);
                chk("plate_top", plate_top, m_box[0]);
                chk("plate_bottom", plate_bottom, m_box[1]);
                chk("plate_left", plate_left, m_box[2]);
                chk("plate_right", plate_right, m_box[3]);
                chk("plate_valid", plate_valid, m_locked);
                chk("eval_pulse", eval_pulse, m_pulse);
                chk("eval_ok", eval_ok, m_ok);
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int u, input int d, input int l, input int r);
        max_line_up = 10'(u); max_line_down = 10'(d);
        max_col_left = 10'(l); max_col_right = 10'(r);
        per_frame_vsync = 1'b1;
        repeat (3) tick();
        per_frame_vsync = 1'b0;
        repeat (5) tick();
    endtask

    task automatic rand_edges();
        logic [9:0] t;
        max_line_up   = 10'($urandom_range(0, 400));
        max_line_down = max_line_up + 10'($urandom_range(10, 170));
        max_col_left  = 10'($urandom_range(0, 500));
        max_col_right = max_col_left + 10'($urandom_range(50, 420));
        if ($urandom_range(0, 6) == 0) begin
            t = max_line_up; max_line_up = max_line_down; max_line_down = t;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; per_frame_vsync = 1'b0;
        max_line_up = '0; max_line_down = '0; max_col_left = '0; max_col_right = '0;
        repeat (3) tick();
        chk("rst horizon_start", horizon_start, 0);
        chk("rst horizon_end", horizon_end, 639);
        chk("rst plate_valid", plate_valid, 0);
        chk("rst eval_ok", eval_ok, 0);
        chk("rst eval_pulse", eval_pulse, 0);
        rst = 1'b0;
        tick();

        // Lock after two valid frames.
        frame(100, 140, 200, 420);
        chk("f1 eval_ok", eval_ok, 1);
        chk("f1 plate_valid", plate_valid, 0);
        frame(100, 140, 200, 420);
        chk("lock plate_valid", plate_valid, 1);
        chk("lock plate_top", plate_top, 100);
        chk("lock plate_bottom", plate_bottom, 140);
        chk("lock plate_left", plate_left, 200);
        chk("lock plate_right", plate_right, 420);
        chk("lock horizon_start", horizon_start, 192);
        chk("lock horizon_end", horizon_end, 428);

        // Three misses drop the lock; the box holds for the first two.
        frame(0, 0, 200, 420);
        frame(0, 0, 200, 420);
        chk("miss2 plate_valid", plate_valid, 1);
        chk("miss2 plate_top", plate_top, 100);
        frame(0, 0, 200, 420);
        chk("miss3 plate_valid", plate_valid, 0);
        chk("miss3 horizon_start", horizon_start, 0);
        chk("miss3 horizon_end", horizon_end, 639);

        // Window clamps at both edges.
        frame(100, 140, 4, 300);
        frame(100, 140, 4, 300);
        chk("clamp lo horizon_start", horizon_start, 0);
        chk("clamp lo horizon_end", horizon_end, 308);
        frame(100, 140, 300, 636);
        chk("clamp hi horizon_start", horizon_start, 292);
        chk("clamp hi horizon_end", horizon_end, 639);

        // Size boundaries.
        frame(100, 115, 200, 300); chk("h15 eval_ok", eval_ok, 0);
        frame(100, 261, 200, 300); chk("h161 eval_ok", eval_ok, 0);
        frame(100, 140, 200, 259); chk("w59 eval_ok", eval_ok, 0);
        frame(100, 140, 200, 601); chk("w401 eval_ok", eval_ok, 0);
        frame(100, 116, 200, 300); chk("h16 eval_ok", eval_ok, 1);
        frame(100, 260, 200, 300); chk("h160 eval_ok", eval_ok, 1);
        frame(100, 140, 200, 260); chk("w60 eval_ok", eval_ok, 1);
        frame(100, 140, 200, 600); chk("w400 eval_ok", eval_ok, 1);

        // Valid, invalid, valid, valid from SEARCH.
        en = 1'b0; tick(); en = 1'b1; tick();
        frame(50, 90, 100, 300);  chk("vivv1 plate_valid", plate_valid, 0);
        frame(90, 50, 100, 300);  chk("vivv2 plate_valid", plate_valid, 0);
        frame(50, 90, 100, 300);  chk("vivv3 plate_valid", plate_valid, 0);
        frame(50, 90, 100, 300);  chk("vivv4 plate_valid", plate_valid, 1);

        // en dropped in F+2 while tracking.
        per_frame_vsync = 1'b1; tick(); tick();
        per_frame_vsync = 1'b0; tick(); tick();
        en = 1'b0; tick(); en = 1'b1;
        chk("endrop eval_pulse", eval_pulse, 0);
        chk("endrop plate_valid", plate_valid, 0);
        chk("endrop horizon_start", horizon_start, 0);
        chk("endrop horizon_end", horizon_end, 639);
        repeat (3) tick();

        // Reset at F+1 suppresses that frame's evaluation.
        frame(50, 90, 100, 300);
        frame(50, 90, 100, 300);
        chk("relock plate_valid", plate_valid, 1);
        per_frame_vsync = 1'b1; tick(); tick();
        per_frame_vsync = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rstF1 eval_pulse", eval_pulse, 0);
            tick();
        end
        chk("rstF1 plate_valid", plate_valid, 0);

        // Randomized traffic against the model.
        rand_edges();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 30) per_frame_vsync = ~per_frame_vsync;
            if ($urandom_range(0, 99) < 10) rand_edges();
            en  = ($urandom_range(0, 99) >= 3);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; en = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
